keccak_ifeed: RTL and testbench
===============================

# keccak_ifeed

Byte-to-lane packer and transmitter for the Keccak absorb port. Accepts a message as a byte stream from the upstream Kyber datapath (matrix/seed/ciphertext serializers). Packs each 8 bytes into one 64-bit word, first byte in the MSB. Drives the core's `i_ibytes` / `i_ibytes_valid` / `o_ibytes_ready` handshake together with the mode and length sidebands for the whole message.

## Interface
Parameters:
- BW_CTRL, 2, width of mode field
- DEPTH, 2, output word buffer entries (power of two, ≥2)
- MAX_ILEN, 1184, maximum message length in bytes

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  begin message; samples i_mode/i_ibyte_len/i_obyte_len
- i_mode  in  BW_CTRL  Keccak mode for this message
- i_ibyte_len  in  11  message length in bytes
- i_obyte_len  in  10  requested output length in bytes
- i_byte  in  8  message byte
- i_byte_valid  in  1  i_byte valid
- o_byte_ready  out  1  byte accepted when valid&ready
- o_ibytes  out  64  packed word to Keccak core
- o_ibytes_valid  out  1  o_ibytes valid
- i_ibytes_ready  in  1  core accepts word when valid&ready
- o_mode  out  BW_CTRL  latched mode, stable while busy
- o_ibyte_len  out  11  latched (clamped) length
- o_obyte_len  out  10  latched output length
- o_busy  out  1  message in progress
- o_done  out  1  one-cycle pulse, last word accepted by core

## Operation
- States: IDLE, PACK, DRAIN.
- IDLE: i_start=1 latches sidebands and zeroes the byte counter.
  - Length is clamped to MAX_ILEN.
  - Length 0: go directly to DRAIN with an empty buffer, so o_done pulses the next cycle.
  - Otherwise go to PACK.
  - i_start while not IDLE is ignored.
- PACK:
  - Each accepted byte goes into the shift-pack register at byte lane 7−(cnt mod 8), i.e. bits [63−8k -: 8].
  - 11-bit byte counter increments per accepted byte.
  - When the 8th byte of a word, or the final message byte, is accepted, the word is pushed to the buffer. Unfilled low lanes are zero.
  - On the final byte go to DRAIN.
- DRAIN: when the buffer is empty and the last word has been accepted, pulse o_done and go to IDLE.
- Buffer:
  - DEPTH-entry circular FIFO; read/write pointers wrap modulo DEPTH; occupancy counter has width log2(DEPTH)+1.
  - o_ibytes/o_ibytes_valid come from the head entry.
  - Push and pop may occur in the same cycle.
- o_byte_ready = (state==PACK) && (occupancy<DEPTH || (o_ibytes_valid && i_ibytes_ready)). This is the only combinational input-to-output path.
- Word count sent = ceil(len/8); maximum 148 words.

## Timing
- Reset values:
  - o_byte_ready, o_ibytes_valid, o_busy, o_done = 0.
  - o_ibytes = 0.
  - o_mode, o_ibyte_len, o_obyte_len = 0.
  - State = IDLE, pointers and counters = 0.
- i_rst mid-message discards buffer and counters in one cycle; no o_done.
- o_busy rises the cycle after i_start and falls the cycle after o_done.
- Latency: the word completed by a byte accepted in cycle t is valid at o_ibytes in t+1 when the buffer was empty.
- Sustained throughput: 1 byte/cycle in, 1 word per 8 cycles out.
- o_ibytes_valid, once high, holds with o_ibytes stable until accepted (no retraction).
- o_done pulses in the cycle after the last word's valid&ready.
- Sidebands are stable from the cycle after i_start until o_done inclusive.

## Structure
- Shared keccak package holds:
  - the Kyber byte limits (MAX_ILEN=1184, max output 784);
  - the mode encodings;
  - the state enum IDLE/PACK/DRAIN.
- One sub-module: `keccak_word_fifo` (DEPTH×64 circular buffer with push/pop/full/empty/count).
- Packing FSM, byte counter and sideband latches live in the top.

## Test plan
- len=16, bytes 0x00..0x0F, ready always 1: words 0x0001020304050607 then 0x08090A0B0C0D0E0F; o_done one cycle after the 2nd accept.
- len=5, bytes 0x01..0x05: single word 0x0102030405000000.
- len=24, i_ibytes_ready held 0 for 30 cycles: o_byte_ready drops after 16 bytes (2 words buffered). Release gives three words in order, none lost or duplicated; o_ibytes stable while stalled.
- len=0 start: no o_ibytes_valid; o_done exactly one cycle later; o_busy high for 2 cycles.
- len=168 with i_rst asserted after 50 bytes: all outputs 0 next cycle. A new len=8 message then produces one correct word.
- Second i_start with a different mode during PACK: ignored, o_mode unchanged. len=1200 start: o_ibyte_len reads 1184 and 148 words are sent.

Source files
------------

// File: rtl/keccak_ifeed_pkg.sv
// Shared Keccak/Kyber definitions: byte limits, mode encodings and feeder FSM states.
package keccak_ifeed_pkg;

    localparam int KYBER_MAX_ILEN = 1184;
    localparam int KYBER_MAX_OLEN = 784;

    typedef enum logic [1:0] {
        MODE_SHA3_256 = 2'd0,
        MODE_SHA3_512 = 2'd1,
        MODE_SHAKE128 = 2'd2,
        MODE_SHAKE256 = 2'd3
    } keccak_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_DRAIN = 2'd2
    } ifeed_state_t;

endpackage

// File: rtl/keccak_word_fifo.sv
// DEPTH x W circular word buffer; head is shown combinationally, zero when empty.
// Push is dropped when full unless a pop happens in the same cycle.
module keccak_word_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [W-1:0]  head_dat
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign head_dat = empty ? '0 : mem[rd_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_q] <= push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/keccak_ifeed.sv
// Packs a byte stream into 64-bit MSB-first words for the Keccak absorb port.
// Word valid one cycle after its last byte; byte ready drops when the word buffer is full.
module keccak_ifeed
    import keccak_ifeed_pkg::*;
#(
    parameter int BW_CTRL  = 2,
    parameter int DEPTH    = 2,
    parameter int MAX_ILEN = KYBER_MAX_ILEN
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [BW_CTRL-1:0] i_mode,
    input  logic [10:0]        i_ibyte_len,
    input  logic [9:0]         i_obyte_len,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    output logic               o_byte_ready,
    output logic [63:0]        o_ibytes,
    output logic               o_ibytes_valid,
    input  logic               i_ibytes_ready,
    output logic [BW_CTRL-1:0] o_mode,
    output logic [10:0]        o_ibyte_len,
    output logic [9:0]         o_obyte_len,
    output logic               o_busy,
    output logic               o_done
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifeed_state_t       state_q, state_d;
    logic [10:0]        cnt_q, len_q, len_clamp;
    logic [63:0]        pack_q, word;
    logic [BW_CTRL-1:0] mode_q;
    logic [9:0]         olen_q;
    logic               busy_q, done_q;
    logic               start_go, accept, last_byte, push, pop, full, empty, done_set;
    logic [CW-1:0]      count;
    logic [2:0]         lane;

    assign len_clamp = (i_ibyte_len > 11'(MAX_ILEN)) ? 11'(MAX_ILEN) : i_ibyte_len;
    assign start_go  = (state_q == ST_IDLE) && i_start;
    assign accept    = i_byte_valid && o_byte_ready;
    assign last_byte = ((cnt_q + 11'd1) == len_q);
    assign push      = accept && ((cnt_q[2:0] == 3'b111) || last_byte);
    assign pop       = o_ibytes_valid && i_ibytes_ready;
    assign lane      = 3'd7 - cnt_q[2:0];

    // Insert the incoming byte into its lane; earlier lanes already hold their bytes.
    always_comb begin
        word = pack_q;
        word[{lane, 3'b000} +: 8] = i_byte;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (i_start) state_d = (len_clamp == '0) ? ST_DRAIN : ST_PACK;
            ST_PACK:  if (accept && last_byte) state_d = ST_DRAIN;
            ST_DRAIN: if (done_set) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Done is decided while the final pop is in flight so the pulse lands the cycle after it.
    always_comb begin
        o_byte_ready = 1'b0;
        done_set     = 1'b0;
        unique case (state_q)
            ST_PACK:  o_byte_ready = !full || pop;
            ST_DRAIN: done_set = empty || ((count == CW'(1)) && pop);
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            len_q  <= '0;
            pack_q <= '0;
            mode_q <= '0;
            olen_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (start_go) begin
                mode_q <= i_mode;
                len_q  <= len_clamp;
                olen_q <= i_obyte_len;
                cnt_q  <= '0;
                pack_q <= '0;
            end else if (accept) begin
                cnt_q  <= cnt_q + 11'd1;
                pack_q <= push ? '0 : word;
            end
            done_q <= done_set;
            if (start_go)    busy_q <= 1'b1;
            else if (done_q) busy_q <= 1'b0;
        end
    end

    keccak_word_fifo #(
        .DEPTH (DEPTH),
        .W     (64)
    ) u_word_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (push),
        .push_dat (word),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .head_dat (o_ibytes)
    );

    assign o_ibytes_valid = !empty;
    assign o_mode         = mode_q;
    assign o_ibyte_len    = len_q;
    assign o_obyte_len    = olen_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule

// File: tb/tb_keccak_ifeed.sv
// Randomized bench for keccak_ifeed with a byte-queue reference model of the word packing.
`timescale 1ns/1ps
module tb_keccak_ifeed;
    import keccak_ifeed_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst, i_start;
    logic [1:0]  i_mode;
    logic [10:0] i_ibyte_len;
    logic [9:0]  i_obyte_len;
    logic [7:0]  i_byte;
    logic        i_byte_valid, o_byte_ready;
    logic [63:0] o_ibytes;
    logic        o_ibytes_valid, i_ibytes_ready;
    logic [1:0]  o_mode;
    logic [10:0] o_ibyte_len;
    logic [9:0]  o_obyte_len;
    logic        o_busy, o_done;

    int checks = 0;
    int failures = 0;

    logic [7:0]  msg[$];
    logic [63:0] got[$];
    int  done_cnt, done_at, last_pop_at, first_vld_at, byte8_at, busy_cyc;
    int  unstable, side_bad, block_at, ilen_seen;
    bit  timed_out;
    logic [1:0]  exp_mode;
    logic [10:0] exp_ilen;
    logic [9:0]  exp_olen;
    logic [90:0] post_rst;

    keccak_ifeed #(.BW_CTRL(2), .DEPTH(2), .MAX_ILEN(KYBER_MAX_ILEN)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
        .i_ibyte_len(i_ibyte_len), .i_obyte_len(i_obyte_len),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
        .o_ibytes(o_ibytes), .o_ibytes_valid(o_ibytes_valid), .i_ibytes_ready(i_ibytes_ready),
        .o_mode(o_mode), .o_ibyte_len(o_ibyte_len), .o_obyte_len(o_obyte_len),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    // Reference: word w holds message bytes 8w..8w+7, first byte in the top lane, zero-padded.
    function automatic logic [63:0] exp_word(int w);
        logic [63:0] x = '0;
        for (int j = 0; j < 8; j++)
            if (8*w + j < msg.size()) x[63-8*j -: 8] = msg[8*w + j];
        return x;
    endfunction

    function automatic int word_errs();
        int bad = 0;
        int nw  = (msg.size() + 7) / 8;
        if (got.size() != nw) bad++;
        for (int i = 0; i < got.size() && i < nw; i++)
            if (got[i] !== exp_word(i)) bad++;
        return bad;
    endfunction

    task automatic run_msg(input int len, input logic [1:0] mode, input int vpct, input int rpct,
                           input int stall, input int restart_at, input int rst_at_byte, input int base);
        int idx = 0;
        int n = 0;
        int L;
        bit pv = 0;
        logic [63:0] prev = '0;
        L = (len > KYBER_MAX_ILEN) ? KYBER_MAX_ILEN : len;
        msg.delete();
        got.delete();
        for (int i = 0; i < L; i++) msg.push_back((base >= 0) ? 8'(base + i) : 8'($urandom));
        done_cnt = 0; done_at = -1; last_pop_at = -1; first_vld_at = -1; byte8_at = -1;
        busy_cyc = 0; unstable = 0; side_bad = 0; block_at = -1; ilen_seen = -1; timed_out = 0;
        post_rst = '1;
        exp_mode = mode;
        exp_ilen = 11'(L);
        exp_olen = 10'($urandom_range(KYBER_MAX_OLEN));
        i_start = 1'b1; i_mode = mode; i_ibyte_len = 11'(len); i_obyte_len = exp_olen;
        i_byte_valid = 1'b0; i_ibytes_ready = 1'b0;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_mode = ~mode; i_ibyte_len = 11'($urandom); i_obyte_len = 10'($urandom);
        while (n < 20000) begin
            if (rst_at_byte >= 0 && idx == rst_at_byte) begin
                i_rst = 1'b1; i_byte_valid = 1'b0; i_ibytes_ready = 1'b0;
                @(posedge i_clk); #1;
                i_rst = 1'b0;
                @(negedge i_clk);
                post_rst = {o_byte_ready, o_ibytes_valid, o_busy, o_done, o_ibytes,
                            o_mode, o_ibyte_len, o_obyte_len};
                if (o_done) done_cnt++;
                break;
            end
            i_start = (n == restart_at);
            if (n == restart_at) i_ibyte_len = 11'd3;
            i_byte_valid   = (idx < L) && ($urandom_range(99) < vpct);
            i_byte         = (idx < L) ? msg[idx] : 8'h00;
            i_ibytes_ready = (n >= stall) && ($urandom_range(99) < rpct);
            @(negedge i_clk);
            if (pv && (!o_ibytes_valid || o_ibytes !== prev)) unstable++;
            pv   = o_ibytes_valid && !i_ibytes_ready;
            prev = o_ibytes;
            if (o_ibytes_valid && first_vld_at < 0) first_vld_at = n;
            if (o_ibytes_valid && i_ibytes_ready) begin
                got.push_back(o_ibytes);
                last_pop_at = n;
            end
            if (n < stall && i_byte_valid && !o_byte_ready && block_at < 0) block_at = idx;
            if (i_byte_valid && o_byte_ready) begin
                idx++;
                if (idx == 8) byte8_at = n;
            end
            if (o_busy) begin
                busy_cyc++;
                if (ilen_seen < 0) ilen_seen = int'(o_ibyte_len);
                if (o_mode !== exp_mode || o_ibyte_len !== exp_ilen || o_obyte_len !== exp_olen)
                    side_bad++;
            end
            if (o_done) begin
                done_cnt++;
                done_at = n;
                if (!o_busy) side_bad++;
            end
            @(posedge i_clk); #1;
            n++;
            if (done_cnt > 0 && n > done_at + 3) break;
        end
        if (n >= 20000) timed_out = 1;
        i_start = 1'b0; i_byte_valid = 1'b0; i_ibytes_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b1; i_mode = 2'd3; i_ibyte_len = 11'd9; i_obyte_len = 10'd5;
        i_byte = 8'hA5; i_byte_valid = 1'b1; i_ibytes_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_start = 1'b0; i_byte_valid = 1'b0; i_ibytes_ready = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({o_byte_ready, o_ibytes_valid, o_busy, o_done, o_ibytes, o_mode, o_ibyte_len, o_obyte_len} !== 91'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {o_byte_ready, o_ibytes_valid, o_busy, o_done,
                     o_ibytes, o_mode, o_ibyte_len, o_obyte_len});
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_len16();
        run_msg(16, MODE_SHAKE128, 100, 100, 0, -1, -1, 0);
        checks++;
        if (got.size() != 2 || got[0] !== 64'h0001020304050607 || got[1] !== 64'h08090A0B0C0D0E0F) begin
            failures++;
            $display("FAIL len16_words n=%0d w0=%h w1=%h exp 0001020304050607/08090a0b0c0d0e0f",
                     got.size(), (got.size() > 0) ? got[0] : 64'h0, (got.size() > 1) ? got[1] : 64'h0);
        end
        checks++;
        if (done_cnt != 1 || done_at != last_pop_at + 1) begin
            failures++;
            $display("FAIL len16_done cnt=%0d at=%0d exp cnt=1 at=%0d", done_cnt, done_at, last_pop_at + 1);
        end
        checks++;
        if (first_vld_at != byte8_at + 1) begin
            failures++;
            $display("FAIL len16_latency valid_at=%0d exp=%0d", first_vld_at, byte8_at + 1);
        end
        checks++;
        if (side_bad != 0) begin
            failures++;
            $display("FAIL len16_sideband bad=%0d exp=0", side_bad);
        end
    endtask

    task automatic test_len5();
        run_msg(5, MODE_SHA3_256, 100, 100, 0, -1, -1, 1);
        checks++;
        if (got.size() != 1 || got[0] !== 64'h0102030405000000) begin
            failures++;
            $display("FAIL len5_word n=%0d w0=%h exp 0102030405000000",
                     got.size(), (got.size() > 0) ? got[0] : 64'h0);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL len5_done cnt=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_stall();
        run_msg(24, MODE_SHAKE256, 100, 100, 30, -1, -1, -1);
        checks++;
        if (block_at != 16) begin
            failures++;
            $display("FAIL stall_block bytes=%0d exp=16", block_at);
        end
        checks++;
        if (word_errs() != 0) begin
            failures++;
            $display("FAIL stall_words n=%0d errs=%0d exp n=3 errs=0", got.size(), word_errs());
        end
        checks++;
        if (unstable != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL stall_hold unstable=%0d done=%0d exp 0/1", unstable, done_cnt);
        end
    endtask

    task automatic test_len0();
        run_msg(0, MODE_SHA3_512, 100, 100, 0, -1, -1, -1);
        checks++;
        if (got.size() != 0 || first_vld_at != -1) begin
            failures++;
            $display("FAIL len0_novalid n=%0d first=%0d exp 0/-1", got.size(), first_vld_at);
        end
        checks++;
        if (done_cnt != 1 || done_at != 1) begin
            failures++;
            $display("FAIL len0_done cnt=%0d at=%0d exp 1/1", done_cnt, done_at);
        end
        checks++;
        if (busy_cyc != 2) begin
            failures++;
            $display("FAIL len0_busy cycles=%0d exp=2", busy_cyc);
        end
    endtask

    task automatic test_reset_mid();
        run_msg(168, MODE_SHAKE128, 100, 60, 0, -1, 50, -1);
        checks++;
        if (post_rst !== 91'd0 || done_cnt != 0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h done=%0d exp 0/0", post_rst, done_cnt);
        end
        run_msg(8, MODE_SHAKE256, 100, 100, 0, -1, -1, -1);
        checks++;
        if (word_errs() != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL midrst_after n=%0d errs=%0d done=%0d exp 1/0/1", got.size(), word_errs(), done_cnt);
        end
    endtask

    task automatic test_restart();
        run_msg(40, MODE_SHA3_512, 100, 100, 0, 10, -1, -1);
        checks++;
        if (side_bad != 0) begin
            failures++;
            $display("FAIL restart_sideband bad=%0d exp=0", side_bad);
        end
        checks++;
        if (word_errs() != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL restart_words n=%0d errs=%0d done=%0d exp 5/0/1", got.size(), word_errs(), done_cnt);
        end
    endtask

    task automatic test_clamp();
        run_msg(1200, MODE_SHAKE128, 100, 100, 0, -1, -1, -1);
        checks++;
        if (ilen_seen != 1184) begin
            failures++;
            $display("FAIL clamp_len got=%0d exp=1184", ilen_seen);
        end
        checks++;
        if (got.size() != 148 || word_errs() != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL clamp_words n=%0d errs=%0d done=%0d exp 148/0/1", got.size(), word_errs(), done_cnt);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int len = $urandom_range(120, 1);
            run_msg(len, 2'($urandom), $urandom_range(100, 30), $urandom_range(100, 30), 0, -1, -1, -1);
            checks++;
            if (word_errs() != 0 || timed_out) begin
                failures++;
                $display("FAIL rand%0d_words len=%0d n=%0d errs=%0d timeout=%0d", k, len, got.size(),
                         word_errs(), timed_out);
            end
            checks++;
            if (done_cnt != 1 || done_at != last_pop_at + 1 || unstable != 0 || side_bad != 0) begin
                failures++;
                $display("FAIL rand%0d_ctrl done=%0d at=%0d exp_at=%0d unstable=%0d side=%0d", k,
                         done_cnt, done_at, last_pop_at + 1, unstable, side_bad);
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_mode = '0; i_ibyte_len = '0; i_obyte_len = '0;
        i_byte = '0; i_byte_valid = 1'b0; i_ibytes_ready = 1'b0;
        test_reset();
        test_len16();
        test_len5();
        test_stall();
        test_len0();
        test_reset_mid();
        test_restart();
        test_clamp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
